// File: rtl/cix_seq.sv
// Sequential count-leading/trailing-zeros/ones and popcount unit, one C-bit chunk per cycle.
// Define CIX_SEQ_EARLY_EXIT_EN to end clz/ctz runs at the terminating chunk instead of after N chunks.
module cix_seq #(
  parameter int ORDER  = 5,
  parameter int CORDER = 3
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    clz,
  input  logic                    ctz,
  input  logic                    inv,
  input  logic [(1<<ORDER)-1:0]   in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ORDER:0]          out,
  output logic                    zero
);

  localparam int W  = 1 << ORDER;
  localparam int C  = 1 << CORDER;
  localparam int N  = W / C;
  localparam int IW = (ORDER > CORDER) ? (ORDER - CORDER) : 1;

  localparam logic [IW-1:0]  IDX_HI  = IW'(N - 1);
  localparam logic [IW-1:0]  IDX_ONE = IW'(1);
  localparam logic [ORDER:0] ONE     = (ORDER + 1)'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]     r_state;
  logic [W-1:0]   r_word;
  logic           r_clz;
  logic           r_ctz;
  logic [ORDER:0] r_acc;
  logic [IW-1:0]  r_idx;
  logic           r_stop;
  logic           r_zero;

  logic [W-1:0]   w_opnd;
  logic [C-1:0]   w_chunk;
  logic [ORDER:0] w_cnt;
  logic           w_single;
  logic           w_null;
  logic           w_hit;
  logic           w_last;
  logic [IW-1:0]  w_end_idx;

  function automatic logic [ORDER:0] f_lead_zeros(input logic [C-1:0] c);
    logic [ORDER:0] n;
    logic           hit;
    n   = '0;
    hit = 1'b0;
    for (int i = C - 1; i >= 0; i--) begin
      if (c[i]) hit = 1'b1;
      else if (!hit) n = n + ONE;
    end
    return n;
  endfunction

  function automatic logic [ORDER:0] f_trail_zeros(input logic [C-1:0] c);
    logic [ORDER:0] n;
    logic           hit;
    n   = '0;
    hit = 1'b0;
    for (int i = 0; i < C; i++) begin
      if (c[i]) hit = 1'b1;
      else if (!hit) n = n + ONE;
    end
    return n;
  endfunction

  function automatic logic [ORDER:0] f_zero_bits(input logic [C-1:0] c);
    logic [ORDER:0] n;
    n = '0;
    for (int i = 0; i < C; i++) begin
      if (!c[i]) n = n + ONE;
    end
    return n;
  endfunction

  assign w_opnd    = inv ? ~in : in;
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out       = r_acc;
  assign zero      = r_zero;

  always_comb begin
    w_chunk = r_word[C-1:0];
    for (int i = 0; i < N; i++) begin
      if (r_idx == IW'(i)) w_chunk = r_word[i*C +: C];
    end
  end

  always_comb begin
    w_single  = r_clz ^ r_ctz;
    w_null    = !r_clz && !r_ctz;
    w_hit     = w_single && (w_chunk != '0);
    w_end_idx = (r_clz && !r_ctz) ? '0 : IDX_HI;
    if (r_clz && r_ctz)  w_cnt = f_zero_bits(w_chunk);
    else if (r_clz)      w_cnt = f_lead_zeros(w_chunk);
    else if (r_ctz)      w_cnt = f_trail_zeros(w_chunk);
    else                 w_cnt = '0;
`ifdef CIX_SEQ_EARLY_EXIT_EN
    w_last = w_null || (r_idx == w_end_idx) || w_hit;
`else
    w_last = w_null || (r_idx == w_end_idx);
`endif
  end

  // operand and op latch: only consumed during RUN, so no reset needed
  always_ff @(posedge clock) begin
    if (r_state == S_IDLE && in_valid) begin
      r_word <= w_opnd;
      r_clz  <= clz;
      r_ctz  <= ctz;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_idx   <= '0;
      r_stop  <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_acc   <= '0;
            r_idx   <= (clz && !ctz) ? IDX_HI : '0;
            r_stop  <= 1'b0;
            r_zero  <= (w_opnd == '0);
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // once a single-sided count has terminated, later chunks are ignored
          if (!r_stop) r_acc <= r_acc + w_cnt;
          if (w_hit)   r_stop <= 1'b1;
          if (w_last) begin
            r_state <= S_DONE;
          end else if (r_clz && !r_ctz) begin
            r_idx <= r_idx - IDX_ONE;
          end else begin
            r_idx <= r_idx + IDX_ONE;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cix_seq.sv
// Scoreboard bench for cix_seq: driver pushes expected results, a negedge monitor pops and compares.
module tb_cix_seq;
  localparam int ORDER  = 5;
  localparam int CORDER = 3;
  localparam int W      = 32;

  logic           clock     = 1'b0;
  logic           reset_n   = 1'b0;
  logic           in_valid  = 1'b0;
  logic           in_ready;
  logic           clz       = 1'b0;
  logic           ctz       = 1'b0;
  logic           inv       = 1'b0;
  logic [W-1:0]   in_w      = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [ORDER:0] out_w;
  logic           zero;

  typedef struct {
    logic [ORDER:0] o;
    logic           z;
    int             cyc;
    string          name;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   cyc    = 0;
  int   n_pass = 0;
  int   n_chk  = 0;
  bit   prev_ov = 1'b0;

  cix_seq #(.ORDER(ORDER), .CORDER(CORDER)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .clz       (clz),
    .ctz       (ctz),
    .inv       (inv),
    .in        (in_w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_w),
    .zero      (zero)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", nm, act, req);
  endtask

  // monitor: compare every new result against the oldest pending expectation
  always @(negedge clock) begin
    if (out_valid && !prev_ov) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_result: got out=%0d zero=%0d, required no result", out_w, zero);
      end else begin
        m_e = sb.pop_front();
        check({m_e.name, "_out"},  32'(out_w), 32'(m_e.o));
        check({m_e.name, "_zero"}, 32'(zero),  32'(m_e.z));
        check({m_e.name, "_lat"},  cyc,        m_e.cyc);
      end
    end
    prev_ov = out_valid;
  end

  task automatic send(input string nm, input bit c_lz, input bit c_tz, input bit c_inv,
                      input logic [31:0] d, input int e_out, input bit e_z, input int k_early,
                      input bit push, input bit hold);
    int   k;
    int   guard;
    exp_t e;
    @(negedge clock);
    clz = c_lz; ctz = c_tz; inv = c_inv; in_w = d; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    if (!in_ready) begin
      n_chk++;
      $display("FAIL %s_accept: in_ready=0, required 1 within 100 cycles", nm);
      in_valid = 1'b0;
      return;
    end
`ifdef CIX_SEQ_EARLY_EXIT_EN
    k = k_early;
`else
    k = (!c_lz && !c_tz) ? 1 : 4;
`endif
    if (push) begin
      e.o = (ORDER + 1)'(e_out); e.z = e_z; e.cyc = cyc + 1 + k; e.name = nm;
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || out_valid) && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  guard;
    bit  seen;
    #2;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out",       32'(out_w),     32'd0);
    check("rst_zero",      32'(zero),      32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // directed vectors: name, clz, ctz, inv, operand, out, zero, k with early exit
    send("clz_15",  1, 0, 0, 32'h0001_0000, 15, 0, 2, 1, 0);
    send("ctz_0",   0, 1, 0, 32'h0000_0000, 32, 1, 4, 1, 0);
    send("pop_inv", 1, 1, 1, 32'hF0F0_0001,  9, 0, 4, 1, 0);
    send("cto_8",   0, 1, 1, 32'h0000_00FF,  8, 0, 2, 1, 0);
    send("null_0",  0, 0, 0, 32'h0000_0000,  0, 1, 1, 1, 0);
    send("clz_msb", 1, 0, 0, 32'h8000_0000,  0, 0, 1, 1, 0);
    send("ctz_mid", 0, 1, 0, 32'h8000_0100,  8, 0, 2, 1, 0);
    send("clo_all", 1, 0, 1, 32'hFFFF_FFFF, 32, 1, 4, 1, 0);
    send("zc_full", 1, 1, 0, 32'hFFFF_FFFF,  0, 0, 4, 1, 0);
    send("clz_24",  1, 0, 0, 32'h0000_00F0, 24, 0, 4, 1, 0);
    wait_drain();

    // backpressure in DONE with a competing request
    @(negedge clock);
    out_ready = 1'b0;
    send("stall", 1, 0, 0, 32'h0000_1000, 19, 0, 3, 1, 0);
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    check("stall_reached_done", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; clz = 1'b0; ctz = 1'b1; inv = 1'b0; in_w = 32'h1234_5678;
      check("stall_valid",    32'(out_valid), 32'd1);
      check("stall_out",      32'(out_w),     32'd19);
      check("stall_zero",     32'(zero),      32'd0);
      check("stall_in_ready", 32'(in_ready),  32'd0);
      @(negedge clock);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    check("release_valid",    32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready),  32'd1);
    wait_drain();

    // reset in the middle of a run aborts it
    send("abort", 0, 1, 0, 32'h0000_0000, 32, 1, 4, 0, 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out",       32'(out_w),     32'd0);
    check("abort_zero",      32'(zero),      32'd0);
    check("abort_in_ready",  32'(in_ready),  32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_result", 32'(seen), 32'd0);

    // back-to-back with in_valid held high
    send("b2b_null", 0, 0, 0, 32'h0000_0005,  0, 0, 1, 1, 1);
    send("b2b_clz",  1, 0, 0, 32'h0000_0001, 31, 0, 4, 1, 1);
    send("b2b_cto",  0, 1, 1, 32'hFFFF_FFFF, 32, 1, 4, 1, 0);
    wait_drain();

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cix_seq.md
CIX_SEQ -- requirements
Module: cix_seq

Interface
- REQ-001 Parameter ORDER, default 5: word width W = 2**ORDER bits.
- REQ-002 Parameter CORDER, default 3: chunk width C = 2**CORDER bits; N = W/C chunks; 1 <= CORDER <= ORDER.
- REQ-003 clock  in  1  sole clock; all state changes on rising edge.
- REQ-004 reset_n  in  1  reset; asynchronous, active-low.
- REQ-005 in_valid  in  1  request present.
- REQ-006 in_ready  out  1  block can accept a request.
- REQ-007 clz  in  1  count from MSB side.
- REQ-008 ctz  in  1  count from LSB side.
- REQ-009 inv  in  1  invert operand before counting (ones-count variants).
- REQ-010 in  in  W  operand word.
- REQ-011 out_valid  out  1  result present.
- REQ-012 out_ready  in  1  consumer takes result.
- REQ-013 out  out  ORDER+1  count result, 0..W.
- REQ-014 zero  out  1  counted (post-inversion) word was all zeros.

Function
- REQ-015 Op encoding: clz only = leading zeros; ctz only = trailing zeros; both = zero count; inv=1 turns these into leading ones, trailing ones and popcount; clz=ctz=0 is the null op.
- REQ-016 States: IDLE, RUN, DONE; in_ready = (state == IDLE).
- REQ-017 On in_valid & in_ready, latch (inv ? ~in : in), clz and ctz; clear the accumulator; set the chunk index to N-1 for clz-only and to 0 for all other ops; go to RUN.
- REQ-018 RUN processes one C-bit chunk per cycle and adds that chunk's count to a (ORDER+1)-bit accumulator. Chunk count = leading zeros (clz), trailing zeros (ctz) or zeros in chunk (both). The accumulator never exceeds W, so no overflow occurs.
- REQ-019 Chunk order: MSB chunk first, descending, for clz-only; LSB chunk first, ascending, otherwise.
- REQ-020 clz-only and ctz-only: the first chunk that is not all-zero terminates the count. Later chunks SHALL NOT change the accumulator.
- REQ-021 Null op: one RUN cycle, out = 0, zero = (latched word == 0).
- REQ-022 RUN -> DONE after the last required chunk, see REQ-029. In DONE, out_valid = 1, and out and zero hold the result.
- REQ-023 zero = 1 iff all W latched bits are 0. For clz/ctz this equals out == W.
- REQ-024 DONE -> IDLE on out_ready. out and zero SHALL stay stable while out_valid=1 and out_ready=0.
- REQ-025 Latency: out_valid rises k cycles after the accept edge, where k is the number of RUN cycles. No new request is accepted until after the DONE -> IDLE transition.
- REQ-026 in, clz, ctz and inv are ignored outside the accept cycle.

Reset
- REQ-027 reset_n low SHALL asynchronously force state to IDLE, out_valid=0, out=0, zero=0 and in_ready=1. Reset clears the accumulator and chunk index.
- REQ-028 Reset during RUN or DONE aborts the operation. No result is presented after release.

Configuration
- REQ-029 Macro CIX_SEQ_EARLY_EXIT_EN controls termination:
  - Defined: clz/ctz RUN ends in the cycle its terminating chunk is processed (k = 1..N), and zero/ones ops take k = N.
  - Undefined: every non-null op takes k = N, the accumulator is frozen after the terminating chunk, and results are identical in both builds.

Verification (ORDER=5, CORDER=3, early exit defined unless noted)
- REQ-030 clz, in=0x0001_0000 -> out=15, zero=0, k=2.
- REQ-031 ctz, in=0x0000_0000 -> out=32, zero=1, k=4. Without CIX_SEQ_EARLY_EXIT_EN, REQ-030 -> out=15, k=4.
- REQ-032 clz+ctz+inv, in=0xF0F0_0001 -> out=9, zero=0, k=4. ctz+inv, in=0x0000_00FF -> out=8, k=2.
- REQ-033 out_ready held low 5 cycles in DONE -> out_valid=1, out/zero unchanged, in_ready=0, a concurrent in_valid is not accepted. On out_ready=1 -> IDLE next cycle.
- REQ-034 reset_n pulsed low mid-RUN -> out_valid=0, out=0, zero=0, in_ready=1 immediately; no result after release.
- REQ-035 Null op, in=0 -> out=0, zero=1, k=1. Back-to-back requests with in_valid held high -> each accepted only in IDLE, results in order.
